// File: rtl/sr_cmd_sequencer_if.sv
// rtl/sr_cmd_sequencer_if.sv - set/clear command handshake bundle
interface sr_cmd_sequencer_if;
    logic cmd_valid;
    logic cmd_op;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - queued set/clear pulse sequencer for an S-R flip-flop
module sr_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int PULSE          = 1,
    parameter int GAP            = 1,
    parameter int SKIP_REDUNDANT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    sr_cmd_sequencer_if.slave      cmd,
    input  logic                   q_fb,
    output logic                   s,
    output logic                   r,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (PULSE > GAP) ? PULSE : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            s_nxt, r_nxt;
    logic [7:0]      drop_nxt;
    logic            push, pop;
    logic            head_op;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            mem [DEPTH];

    // Ready depends only on registered level so a same-cycle pop never opens a full FIFO.
    assign cmd.cmd_ready = (level != LW'(DEPTH));
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head_op       = mem[rd_ptr];
    assign busy          = (level != '0) || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd.cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            state    <= ST_IDLE;
            cnt      <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            s        <= s_nxt;
            r        <= r_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // s_nxt/r_nxt default low, so only the IDLE pop can raise exactly one of them.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        pop       = 1'b0;
        drop_nxt  = drop_cnt;
        case (state)
            ST_IDLE: begin
                if (level != '0) begin
                    pop = 1'b1;
                    if ((SKIP_REDUNDANT != 0) && (head_op == q_fb)) begin
                        if (drop_cnt != 8'hff) drop_nxt = drop_cnt + 8'd1;
                    end else begin
                        s_nxt     = head_op;
                        r_nxt     = ~head_op;
                        cnt_nxt   = CW'(PULSE - 1);
                        state_nxt = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = CW'(GAP - 1);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    s_nxt   = s;
                    r_nxt   = r;
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
